// File: rtl/ctrl_decode_pipe_if.sv
// Fetch-to-execute handshake bundle for the registered decoder.
// master drives instructions and output-ready; slave is the decoder.
interface ctrl_decode_pipe_if;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] instruction_i;
  logic       cb_i;
  logic       resume_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [3:0] alucontrol_o;
  logic [2:0] rs_addr_o;
  logic [2:0] rt_addr_o;
  logic [2:0] write_addr_o;
  logic [4:0] immediate_o;
  logic       regwrite_o;
  logic       CBwrite_o;
  logic       write_data_control_o;
  logic       memread_o;
  logic       memwrite_o;
  logic       branchf_o;
  logic       branchb_o;
  logic       flushed_o;
  logic       done_o;

  modport master (
    output in_valid_i, instruction_i, cb_i,
    output resume_i, out_ready_i,
    input  in_ready_o, out_valid_o,
    input  alucontrol_o, rs_addr_o, rt_addr_o,
    input  write_addr_o, immediate_o,
    input  regwrite_o, CBwrite_o,
    input  write_data_control_o,
    input  memread_o, memwrite_o,
    input  branchf_o, branchb_o,
    input  flushed_o, done_o
  );

  modport slave (
    input  in_valid_i, instruction_i, cb_i,
    input  resume_i, out_ready_i,
    output in_ready_o, out_valid_o,
    output alucontrol_o, rs_addr_o, rt_addr_o,
    output write_addr_o, immediate_o,
    output regwrite_o, CBwrite_o,
    output write_data_control_o,
    output memread_o, memwrite_o,
    output branchf_o, branchb_o,
    output flushed_o, done_o
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// Registered 8-bit instruction decoder with valid/ready flow control,
// branch-shadow squashing and a halt state.
module ctrl_decode_pipe #(
  parameter int unsigned FLUSH_SLOTS = 1,
  parameter int unsigned ACC_REG     = 7,
  parameter bit          HALT_STICKY = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ctrl_decode_pipe_if.slave bus
);

  localparam logic [2:0] ACC   = 3'(ACC_REG);
  localparam logic [3:0] SLOTS = 4'(FLUSH_SLOTS);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] wa;
    logic [4:0] imm;
    logic       rw;
    logic       cbw;
    logic       wdc;
    logic       mrd;
    logic       mwr;
    logic       bf;
    logic       bb;
    logic       fl;
  } ctrl_t;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q;
  logic       done_q, done_d;
  ctrl_t      ctrl_q, dec, dec_sq;

  logic [4:0] op;
  logic [2:0] f;
  logic       accept, taken, in_ready;

  logic is_and, is_add, is_set, is_sll, is_srl;
  logic is_subs, is_slt, is_seq, is_load, is_store;
  logic is_abs, is_addc, is_brf, is_brb, is_halt;

  assign op = bus.instruction_i[7:3];
  assign f  = bus.instruction_i[2:0];

  assign is_and   = op[4:3] == 2'b00;
  assign is_add   = op[4:3] == 2'b01;
  assign is_set   = op[4:2] == 3'b110;
  assign is_sll   = op == 5'b11100;
  assign is_srl   = op == 5'b11101;
  assign is_brf   = op == 5'b11110;
  assign is_subs  = op == 5'b11111;
  assign is_slt   = op == 5'b10000;
  assign is_halt  = op == 5'b10001;
  assign is_load  = op == 5'b10010;
  assign is_store = op == 5'b10011;
  assign is_abs   = op == 5'b10100;
  assign is_seq   = op == 5'b10101;
  assign is_brb   = op == 5'b10110;
  assign is_addc  = op == 5'b10111;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_and: begin
        dec.alu = 4'd0; dec.rs = f; dec.rt = ACC;
        dec.wa = bus.instruction_i[5:3]; dec.rw = 1'b1;
      end
      is_add: begin
        dec.alu = 4'd1; dec.rs = f; dec.rt = ACC;
        dec.wa = bus.instruction_i[5:3]; dec.rw = 1'b1;
      end
      is_set: begin
        dec.alu = 4'd8; dec.imm = bus.instruction_i[4:0];
        dec.wa = ACC; dec.rw = 1'b1;
      end
      is_sll: begin
        dec.alu = 4'd2; dec.rs = f; dec.wa = f;
        dec.rt = ACC; dec.rw = 1'b1;
      end
      is_srl: begin
        dec.alu = 4'd3; dec.rs = f; dec.wa = f; dec.rw = 1'b1;
      end
      is_subs: begin
        dec.alu = 4'd4; dec.rs = 3'd2; dec.rt = 3'd5;
        dec.wa = f; dec.rw = 1'b1;
      end
      is_slt: begin
        dec.alu = 4'd5; dec.rs = 3'd6; dec.rt = ACC; dec.cbw = 1'b1;
      end
      is_seq: begin
        dec.alu = 4'd7; dec.rs = f; dec.rt = ACC; dec.cbw = 1'b1;
      end
      is_load: begin
        dec.alu = 4'd1; dec.rt = ACC; dec.wa = f; dec.rw = 1'b1;
        dec.wdc = 1'b1; dec.mrd = 1'b1;
      end
      is_store: begin
        dec.alu = 4'd1; dec.rs = f; dec.rt = ACC; dec.mwr = 1'b1;
      end
      is_abs: begin
        dec.alu = 4'd6; dec.rs = f; dec.wa = f; dec.rw = 1'b1;
      end
      is_addc: begin
        dec.alu = 4'd9; dec.rs = f; dec.rt = ACC;
        dec.wa = ACC; dec.rw = 1'b1;
      end
      is_brf: begin
        dec.alu = 4'd1; dec.rs = f; dec.bf = bus.cb_i;
      end
      is_brb: begin
        dec.alu = 4'd1; dec.rs = f; dec.bb = bus.cb_i;
      end
      is_halt: dec.alu = 4'd1;
      default: dec = '0;
    endcase
  end

  // Shadow beats keep their decode for visibility but lose all side effects.
  always_comb begin
    dec_sq = dec;
    if (state_q == S_FLUSH) begin
      dec_sq.rw  = 1'b0;
      dec_sq.cbw = 1'b0;
      dec_sq.mrd = 1'b0;
      dec_sq.mwr = 1'b0;
      dec_sq.bf  = 1'b0;
      dec_sq.bb  = 1'b0;
      dec_sq.fl  = 1'b1;
    end
  end

  assign in_ready = rst_ni & (state_q != S_HALT)
                  & (~valid_q | bus.out_ready_i);
  assign accept   = bus.in_valid_i & in_ready;
  assign taken    = (is_brf | is_brb) & bus.cb_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      S_RUN: begin
        if (accept && taken) begin
          state_d = S_FLUSH;
          cnt_d   = SLOTS;
        end else if (accept && is_halt) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        if (accept) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (!HALT_STICKY && bus.resume_i) begin
          state_d = S_RUN;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (accept) begin
        valid_q <= 1'b1;
        ctrl_q  <= dec_sq;
      end else if (bus.out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready_o           = in_ready;
  assign bus.out_valid_o          = valid_q;
  assign bus.alucontrol_o         = ctrl_q.alu;
  assign bus.rs_addr_o            = ctrl_q.rs;
  assign bus.rt_addr_o            = ctrl_q.rt;
  assign bus.write_addr_o         = ctrl_q.wa;
  assign bus.immediate_o          = ctrl_q.imm;
  assign bus.regwrite_o           = ctrl_q.rw;
  assign bus.CBwrite_o            = ctrl_q.cbw;
  assign bus.write_data_control_o = ctrl_q.wdc;
  assign bus.memread_o            = ctrl_q.mrd;
  assign bus.memwrite_o           = ctrl_q.mwr;
  assign bus.branchf_o            = ctrl_q.bf;
  assign bus.branchb_o            = ctrl_q.bb;
  assign bus.flushed_o            = ctrl_q.fl;
  assign bus.done_o               = done_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe: directed scenarios then
// randomized traffic against a behavioural decode/flow model.
module tb_ctrl_decode_pipe;

  localparam int FS  = 2;
  localparam int ACC = 7;

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] wa;
    logic [4:0] imm;
    logic       rw;
    logic       cbw;
    logic       wdc;
    logic       mrd;
    logic       mwr;
    logic       bf;
    logic       bb;
    logic       fl;
  } bun_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_decode_pipe_if bus();

  ctrl_decode_pipe #(
    .FLUSH_SLOTS(FS),
    .ACC_REG(ACC),
    .HALT_STICKY(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bun_t sb[$];

  int m_pend   = 0;
  int m_shadow = 0;
  bit m_halt   = 0;
  bit m_done   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bun_t dut_bun();
    bun_t a;
    a.alu = bus.alucontrol_o;
    a.rs  = bus.rs_addr_o;
    a.rt  = bus.rt_addr_o;
    a.wa  = bus.write_addr_o;
    a.imm = bus.immediate_o;
    a.rw  = bus.regwrite_o;
    a.cbw = bus.CBwrite_o;
    a.wdc = bus.write_data_control_o;
    a.mrd = bus.memread_o;
    a.mwr = bus.memwrite_o;
    a.bf  = bus.branchf_o;
    a.bb  = bus.branchb_o;
    a.fl  = bus.flushed_o;
    return a;
  endfunction

  function automatic bun_t decode(input logic [7:0] ins, input logic cb);
    bun_t b;
    logic [2:0] f;
    logic [2:0] w;
    b = '0;
    f = ins[2:0];
    w = ins[5:3];
    casez (ins[7:3])
      5'b00???: begin b.alu = 0; b.rs = f; b.rt = ACC; b.wa = w; b.rw = 1; end
      5'b01???: begin b.alu = 1; b.rs = f; b.rt = ACC; b.wa = w; b.rw = 1; end
      5'b110??: begin b.alu = 8; b.imm = ins[4:0]; b.wa = ACC; b.rw = 1; end
      5'b11100: begin b.alu = 2; b.rs = f; b.wa = f; b.rt = ACC; b.rw = 1; end
      5'b11101: begin b.alu = 3; b.rs = f; b.wa = f; b.rw = 1; end
      5'b11111: begin b.alu = 4; b.rs = 2; b.rt = 5; b.wa = f; b.rw = 1; end
      5'b10000: begin b.alu = 5; b.rs = 6; b.rt = ACC; b.cbw = 1; end
      5'b10101: begin b.alu = 7; b.rs = f; b.rt = ACC; b.cbw = 1; end
      5'b10010: begin
        b.alu = 1; b.rt = ACC; b.wa = f; b.rw = 1; b.wdc = 1; b.mrd = 1;
      end
      5'b10011: begin b.alu = 1; b.rs = f; b.rt = ACC; b.mwr = 1; end
      5'b10100: begin b.alu = 6; b.rs = f; b.wa = f; b.rw = 1; end
      5'b10111: begin b.alu = 9; b.rs = f; b.rt = ACC; b.wa = ACC; b.rw = 1; end
      5'b11110: begin b.alu = 1; b.rs = f; b.bf = cb; end
      5'b10110: begin b.alu = 1; b.rs = f; b.bb = cb; end
      default:  b.alu = 1;
    endcase
    return b;
  endfunction

  // One cycle: drive at negedge, predict what the next edge does.
  task automatic step(input bit v, input logic [7:0] ins, input bit cb,
                      input bit ordy, input bit res);
    bit   exp_rdy, acc;
    bun_t b;
    @(negedge clk);
    bus.in_valid_i    = v;
    bus.instruction_i = ins;
    bus.cb_i          = cb;
    bus.out_ready_i   = ordy;
    bus.resume_i      = res;
    #1;
    exp_rdy = !m_halt && (m_pend == 0 || ordy);
    chk("in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid_o), 32'(m_pend != 0));
    chk("done", 32'(bus.done_o), 32'(m_done));
    acc = v && exp_rdy;
    if (m_pend != 0 && ordy) m_pend--;
    if (acc) begin
      b = decode(ins, cb);
      if (m_shadow > 0) begin
        b.rw = 0; b.cbw = 0; b.mrd = 0; b.mwr = 0;
        b.bf = 0; b.bb = 0; b.fl = 1;
        m_shadow--;
      end else if (cb && (ins[7:3] == 5'b11110 || ins[7:3] == 5'b10110)) begin
        m_shadow = FS;
      end else if (ins[7:3] == 5'b10001) begin
        m_halt = 1;
        m_done = 1;
      end
      sb.push_back(b);
      m_pend++;
    end else if (m_halt && res) begin
      m_halt = 0;
      m_done = 0;
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bundle actual=unexpected required=none at %0t", $time);
      end else begin
        chk("bundle", 32'(dut_bun()), 32'(sb.pop_front()));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bundle"}, 32'(dut_bun()), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    bus.in_valid_i    = 0;
    bus.instruction_i = 0;
    bus.cb_i          = 0;
    bus.out_ready_i   = 0;
    bus.resume_i      = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    step(1, 8'h4B, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // Backpressure: held bundle, refused beat, then drain.
    step(1, 8'h4B, 0, 1, 0);
    repeat (3) step(0, 8'h00, 0, 0, 0);
    step(1, 8'hC5, 0, 0, 0);
    step(1, 8'hC5, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // Taken brf then shadowed adds.
    step(1, 8'hF2, 1, 1, 0);
    step(1, 8'h4B, 0, 1, 0);
    step(1, 8'h4B, 0, 1, 0);
    step(1, 8'h4B, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // Branch and halt inside the shadow are squashed.
    step(1, 8'hF2, 1, 1, 0);
    step(1, 8'hB3, 1, 1, 0);
    step(1, 8'h88, 0, 1, 0);
    step(1, 8'h4B, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // Halt, held off for 10 cycles, then resume.
    step(1, 8'h88, 0, 1, 0);
    repeat (10) step(1, 8'h4B, 0, 1, 0);
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'h4B, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    repeat (3000) begin
      step(($urandom % 4) != 0, 8'($urandom), 1'($urandom),
           ($urandom % 4) != 0, m_halt && (($urandom % 6) == 0));
    end
    repeat (20) step(0, 8'h00, 0, 1, 1);

    // Async reset while a bundle is stalled.
    step(1, 8'h4B, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk_all_zero("async_rst");
    sb.delete();
    m_pend = 0; m_shadow = 0; m_halt = 0; m_done = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, 8'hA5, 0, 1, 0);
    repeat (3) step(0, 8'h00, 0, 1, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
